alu_issue_ctrl: RTL and testbench

//  Upstream issue/capture stage for the combinational aluOp datapath. Accepts one

---
 rtl/alu_issue_ctrl.sv | 162 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Issue/capture stage in front of a combinational aluOp datapath.
// A command (a, b, op) is accepted on a valid/ready handshake and registered
// onto the ALU inputs. One cycle later the ALU result and flags are captured.
// They are then held behind a valid/ready result handshake until the consumer
// takes them. The block also counts consumed results (op_cnt, wrapping) and
// consumed results that carried the illegal-opcode flag (err_cnt, saturating
// at 255).
//
// Optional feature macro: ACC_FWD_EN
//   defined   : in_use_acc=1 at acceptance feeds the last captured result
//               (res_data) to alu_a instead of in_a, so accumulate ops chain.
//   undefined : in_use_acc is ignored and alu_a always takes in_a.
//   The port list is the same in both builds.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     command handshake (accepted only in IDLE)
//   in_a, in_b, in_op     command operands and opcode
//   in_use_acc            forward last result as operand A (ACC_FWD_EN only)
//   alu_a, alu_b, alu_op  registered operands/opcode driving the ALU
//   alu_out, alu_of, alu_un, alu_err, alu_zero   ALU result and flags
//   res_valid/res_ready   result handshake
//   res_data, res_flags   captured result and {err, zero, un, of}
//   op_cnt                consumed-result counter, wraps at 2^CNT_W
//   err_cnt               consumed results with err=1, saturates at 255
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int SIZE  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE-1:0]  in_a,
  input  logic [SIZE-1:0]  in_b,
  input  logic [3:0]       in_op,
  input  logic             in_use_acc,
  output logic [SIZE-1:0]  alu_a,
  output logic [SIZE-1:0]  alu_b,
  output logic [3:0]       alu_op,
  input  logic [SIZE-1:0]  alu_out,
  input  logic             alu_of,
  input  logic             alu_un,
  input  logic             alu_err,
  input  logic             alu_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SIZE-1:0]  res_data,
  output logic [3:0]       res_flags,
  output logic [CNT_W-1:0] op_cnt,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SIZE-1:0]   alu_a_q, alu_a_d;
  logic [SIZE-1:0]   alu_b_q, alu_b_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [SIZE-1:0]   res_data_q, res_data_d;
  logic [3:0]        res_flags_q, res_flags_d;
  logic              res_valid_q, res_valid_d;
  logic [CNT_W-1:0]  op_cnt_q, op_cnt_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [SIZE-1:0]   a_sel;

  // Operand A source at acceptance.
`ifdef ACC_FWD_EN
  assign a_sel = in_use_acc ? res_data_q : in_a;
`else
  logic use_acc_unused;
  assign use_acc_unused = in_use_acc;
  assign a_sel          = in_a;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_valid_q <= 1'b0;
      op_cnt_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      res_valid_q <= res_valid_d;
      op_cnt_q    <= op_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    res_valid_d = res_valid_q;
    op_cnt_d    = op_cnt_q;
    err_cnt_d   = err_cnt_q;
    in_ready    = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          alu_a_d  = a_sel;
          alu_b_d  = in_b;
          alu_op_d = in_op;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        // The ALU has had a full cycle to settle on the registered inputs.
        res_data_d  = alu_out;
        res_flags_d = {alu_err, alu_zero, alu_un, alu_of};
        res_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          op_cnt_d    = op_cnt_q + 1'b1;
          if (res_flags_q[3] && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign res_data  = res_data_q;
  assign res_flags = res_flags_q;
  assign res_valid = res_valid_q;
  assign op_cnt    = op_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Bench for alu_issue_ctrl. A behavioural 8-bit ALU drives alu_out/flags from
// the DUT's registered operands. Expected results, flags and counters come
// from integer arithmetic on the commanded operands. Define ACC_FWD_EN for
// both files to exercise result forwarding.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;
  localparam int SIZE  = 8;
  localparam int CNT_W = 16;
`ifdef ACC_FWD_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [SIZE-1:0]  in_a = '0;
  logic [SIZE-1:0]  in_b = '0;
  logic [3:0]       in_op = '0;
  logic             in_use_acc = 1'b0;
  logic [SIZE-1:0]  alu_a, alu_b;
  logic [3:0]       alu_op;
  logic [SIZE-1:0]  alu_out;
  logic             alu_of, alu_un, alu_err, alu_zero;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [SIZE-1:0]  res_data;
  logic [3:0]       res_flags;
  logic [CNT_W-1:0] op_cnt;
  logic [7:0]       err_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  // reference state
  int exp_op_cnt = 0;
  int exp_err_cnt = 0;
  int last_res = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_use_acc(in_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_of(alu_of), .alu_un(alu_un),
    .alu_err(alu_err), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_flags(res_flags),
    .op_cnt(op_cnt), .err_cnt(err_cnt)
  );

  // ALU behaviour: returns {err, zero, un, of, result[7:0]}.
  function automatic logic [11:0] alu_fn(input int a, input int b, input int op);
    int r;
    logic [3:0] f;
    logic [7:0] r8;
    r = 0;
    f = 4'b0000;
    case (op)
      0: begin r = a + b; f[0] = (r > 255); end
      1: begin r = a - b; f[2] = (r < 0); end
      2: begin r = a * 2; f[0] = (r > 255); end
      3: begin f[2] = ((a % 2) == 1); r = a / 2; end
      4: r = (a == b) ? 1 : 0;
      5: r = (a > b) ? 1 : 0;
      6: r = (a < b) ? 1 : 0;
      default: begin r = a ^ b; f[3] = 1'b1; end
    endcase
    r  = ((r % 256) + 256) % 256;
    r8 = r[7:0];
    if (op < 7 && r == 0) f[1] = 1'b1;
    return {f, r8};
  endfunction

  logic [11:0] alu_res;
  always_comb begin
    alu_res = alu_fn(int'(alu_a), int'(alu_b), int'(alu_op));
  end
  assign alu_out  = alu_res[7:0];
  assign alu_err  = alu_res[11];
  assign alu_zero = alu_res[10];
  assign alu_un   = alu_res[9];
  assign alu_of   = alu_res[8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command and consume its result after 'hold' stall cycles.
  // Starts and ends on a falling edge.
  task automatic run_op(input int a, input int b, input int op, input bit use_acc,
                        input int hold, input bit pulse);
    int ea;
    int waited;
    logic [11:0] r;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    ea = (ACC && use_acc) ? last_res : a;
    r  = alu_fn(ea, b, op);
    in_valid   = 1'b1;
    in_a       = a[7:0];
    in_b       = b[7:0];
    in_op      = op[3:0];
    in_use_acc = use_acc;
    res_ready  = 1'b0;
    @(negedge clk);
    // EXEC: inputs change freely, nothing must follow them.
    in_valid = 1'b0;
    in_a     = 8'($urandom_range(0, 255));
    in_b     = 8'($urandom_range(0, 255));
    chk("in_ready_exec", {31'd0, in_ready}, 32'd0);
    chk("res_valid_exec", {31'd0, res_valid}, 32'd0);
    chk("alu_a", {24'd0, alu_a}, ea);
    chk("alu_b", {24'd0, alu_b}, b);
    chk("alu_op", {28'd0, alu_op}, op);
    @(negedge clk);
    chk("res_valid_done", {31'd0, res_valid}, 32'd1);
    if (op < 7) chk("res_data", {24'd0, res_data}, {24'd0, r[7:0]});
    chk("res_flags", {28'd0, res_flags}, {28'd0, r[11:8]});
    for (int h = 0; h < hold; h++) begin
      in_valid = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
      in_a     = 8'($urandom_range(0, 255));
      in_op    = 4'($urandom_range(0, 6));
      @(negedge clk);
      chk("hold_valid", {31'd0, res_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      if (op < 7) chk("hold_data", {24'd0, res_data}, {24'd0, r[7:0]});
      chk("hold_flags", {28'd0, res_flags}, {28'd0, r[11:8]});
      chk("hold_alu_a", {24'd0, alu_a}, ea);
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready   = 1'b0;
    exp_op_cnt  = (exp_op_cnt + 1) % (1 << CNT_W);
    if (r[11] && exp_err_cnt < 255) exp_err_cnt++;
    last_res    = int'(r[7:0]);
    chk("res_valid_after", {31'd0, res_valid}, 32'd0);
    chk("in_ready_after", {31'd0, in_ready}, 32'd1);
    chk("op_cnt", {16'd0, op_cnt}, exp_op_cnt);
    chk("err_cnt", {24'd0, err_cnt}, exp_err_cnt);
    $display("op a=%0d b=%0d op=%0d acc=%0d hold=%0d -> data=%0d flags=%b op_cnt=%0d err_cnt=%0d",
             a, b, op, use_acc, hold, res_data_seen(r), r[11:8], op_cnt, err_cnt);
  endtask

  function automatic int res_data_seen(input logic [11:0] r);
    return int'(r[7:0]);
  endfunction

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_op_cnt", {16'd0, op_cnt}, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    chk("rst_res_data", {24'd0, res_data}, 32'd0);
    chk("rst_res_flags", {28'd0, res_flags}, 32'd0);
    chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
    chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
    in_valid  = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    exp_op_cnt  = 0;
    exp_err_cnt = 0;
    last_res    = 0;
    $display("reset applied");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // power-on reset
    @(negedge clk);
    do_reset();

    // add with overflow, consumed immediately
    run_op(200, 100, 0, 1'b0, 0, 1'b0);
    // sub with underflow, result held 4 cycles while in_valid pulses
    run_op(5, 9, 1, 1'b0, 4, 1'b1);
    // equality false, then less-than true
    run_op(3, 4, 4, 1'b0, 0, 1'b0);
    run_op(3, 4, 6, 1'b0, 0, 1'b0);
    // shifts and compares at the edges
    run_op(255, 0, 2, 1'b0, 1, 1'b0);
    run_op(1, 0, 3, 1'b0, 0, 1'b0);
    run_op(255, 255, 5, 1'b0, 0, 1'b0);

    // reset while a result is pending in DONE
    in_valid = 1'b1; in_a = 8'd200; in_b = 8'd100; in_op = 4'd0; in_use_acc = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pending_valid", {31'd0, res_valid}, 32'd1);
    do_reset();

    // forwarding chain: 10+5, then acc+7 (22 with forwarding, 99+7 without)
    run_op(10, 5, 0, 1'b0, 0, 1'b0);
    run_op(99, 7, 0, 1'b1, 0, 1'b0);
    chk("acc_chain", {24'd0, res_data}, ACC ? 32'd22 : 32'd106);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      run_op($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 8),
             1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b1);
    end

    // error-opcode saturation from a clean start
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 300; i++) begin
      run_op($urandom_range(0, 255), $urandom_range(0, 255), 10, 1'b0, 0, 1'b0);
    end
    chk("err_cnt_sat", {24'd0, err_cnt}, 32'd255);
    chk("op_cnt_300", {16'd0, op_cnt}, 32'd300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
